// File: rtl/sprite_pkg.sv
// sprite_pkg: attribute word layout, render FSM states and sprite size constants
package sprite_pkg;
  localparam int SZ_S = 16;
  localparam int SZ_L = 32;
  typedef enum logic [2:0] {IDLE, FETCH, EVAL, DRAW, FLUSH} state_t;
  typedef struct packed {
    logic [2:0] colour;
    logic       en;
    logic       flipy;
    logic       flipx;
    logic       size;
    logic [8:0] x;
    logic [7:0] y;
    logic [7:0] code;
  } attr_t;
  function automatic logic [5:0] spr_size(input logic big);
    return big ? 6'(SZ_L) : 6'(SZ_S);
  endfunction
endpackage

// File: rtl/sprite_line_engine_if.sv
// sprite_line_engine_if: line control, attribute/pattern memory ports and pixel readout
interface sprite_line_engine_if #(
  parameter int NSPR = 64
);
  logic                    line_start;
  logic [8:0]              line_v;
  logic [$clog2(NSPR)-1:0] atr_ad;
  logic [31:0]             atr_dt;
  logic [17:0]             chr_ad;
  logic [3:0]              chr_dt;
  logic                    pix_en;
  logic [8:0]              pix_x;
  logic [6:0]              pix_col;
  logic                    pix_opq;
  logic                    busy;
  logic                    ovf;
  logic                    late;
  modport master (
    output line_start, line_v, atr_dt, chr_dt, pix_en, pix_x,
    input  atr_ad, chr_ad, pix_col, pix_opq, busy, ovf, late
  );
  modport slave (
    input  line_start, line_v, atr_dt, chr_dt, pix_en, pix_x,
    output atr_ad, chr_ad, pix_col, pix_opq, busy, ovf, late
  );
endinterface

// File: rtl/spr_lbuf.sv
// spr_lbuf: two-bank line colour RAM, one write port and one registered read port
module spr_lbuf #(
  parameter int LBW = 288
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(2*LBW)-1:0]     waddr,
  input  logic [6:0]                   wdata,
  input  logic                         re,
  input  logic [$clog2(2*LBW)-1:0]     raddr,
  output logic [6:0]                   rdata
);
  logic [6:0] mem [2*LBW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: scans sprite attributes for one line and draws hits into a
// double-buffered line buffer while the other buffer is read out.
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int NSPR  = 64,
  parameter int MAXPL = 16,
  parameter int LBW   = 288
) (
  input logic                 RCLK,
  input logic                 RST_N,
  sprite_line_engine_if.slave bus
);
  localparam int IW = $clog2(NSPR);
  localparam int HW = $clog2(MAXPL + 1);
  localparam int AW = $clog2(2 * LBW);
  state_t state, state_nx;
  attr_t a;
  logic [IW-1:0] idx;
  logic [HW-1:0] hits;
  logic [8:0] line_v, dv, x, wr_col;
  logic [7:0] code;
  logic [4:0] v, u, szm1, uu, vv;
  logic [2:0] colour;
  logic big, flipx, flipy, ovf_l, sel, wr_pend, hit, last, do_wr, rd_ok;
  logic [LBW-1:0] opq [2];
  logic [AW-1:0] waddr, raddr;
  logic [6:0] rd_data;
  assign a = attr_t'(bus.atr_dt);
  assign dv = line_v - 9'(a.y);
  assign hit = a.en && dv < 9'(spr_size(a.size));
  assign last = idx == IW'(NSPR - 1);
  assign szm1 = 5'(spr_size(big) - 6'd1);
  assign uu = flipx ? szm1 - u : u;
  assign vv = flipy ? szm1 - v : v;
  assign bus.atr_ad = idx;
  assign bus.chr_ad = state == DRAW ? {code, vv, uu} : '0;
  assign bus.busy = state != IDLE;
  assign bus.pix_col = bus.pix_opq ? rd_data : '0;
  // sel names the front bank; the back bank is ~sel
  assign do_wr = wr_pend && !bus.line_start && bus.chr_dt != 4'd0 && wr_col < 9'(LBW) && !opq[~sel][wr_col];
  assign rd_ok = bus.pix_en && bus.pix_x < 9'(LBW);
  assign waddr = AW'(wr_col) + (sel ? AW'(0) : AW'(LBW));
  assign raddr = AW'(bus.pix_x) + (sel ? AW'(LBW) : AW'(0));
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = EVAL;
      EVAL:    state_nx = (hit && hits < HW'(MAXPL)) ? DRAW : (last ? IDLE : FETCH);
      DRAW:    state_nx = u == szm1 ? FLUSH : DRAW;
      FLUSH:   state_nx = last ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
    if (bus.line_start) state_nx = FETCH;
  end
  always_ff @(posedge RCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= '0;
      hits        <= '0;
      ovf_l       <= 1'b0;
      sel         <= 1'b0;
      wr_pend     <= 1'b0;
      opq         <= '{default: '0};
      bus.ovf     <= 1'b0;
      bus.late    <= 1'b0;
      bus.pix_opq <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.late <= bus.line_start && bus.busy;
      wr_pend  <= state == DRAW && !bus.line_start;
      if (bus.pix_en) bus.pix_opq <= rd_ok && opq[sel][bus.pix_x];
      if (rd_ok) opq[sel][bus.pix_x] <= 1'b0;
      if (do_wr) opq[~sel][wr_col] <= 1'b1;
      if (bus.line_start) begin
        sel     <= ~sel;
        idx     <= '0;
        hits    <= '0;
        ovf_l   <= 1'b0;
        bus.ovf <= ovf_l;
        opq[sel] <= '0;
        // an abandoned render becomes the front bank; hide its partial pixels
        if (bus.busy) opq[~sel] <= '0;
      end else begin
        if (state == EVAL && hit && hits == HW'(MAXPL)) ovf_l <= 1'b1;
        if (state == FLUSH) hits <= hits + HW'(1);
        if ((state == EVAL && state_nx != DRAW) || state == FLUSH) idx <= idx + IW'(1);
      end
    end
  end
  always_ff @(posedge RCLK) begin
    if (bus.line_start) line_v <= bus.line_v;
    if (state == EVAL) begin
      code   <= a.code;
      x      <= a.x;
      big    <= a.size;
      flipx  <= a.flipx;
      flipy  <= a.flipy;
      colour <= a.colour;
      v      <= dv[4:0];
    end
    u      <= state == DRAW ? u + 5'd1 : 5'd0;
    wr_col <= x + 9'(u);
  end
  spr_lbuf #(.LBW(LBW)) u_lbuf (
    .clk   (RCLK),
    .we    (do_wr),
    .waddr (waddr),
    .wdata ({colour, bus.chr_dt}),
    .re    (rd_ok),
    .raddr (raddr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed scenarios with hand-computed line buffer contents
module tb_sprite_line_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] atr [64];
  sprite_line_engine_if #(.NSPR(64)) bus ();
  sprite_line_engine #(.NSPR(64), .MAXPL(16), .LBW(288)) dut (
    .RCLK  (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] pat(input logic [17:0] ad);
    logic [7:0] c;
    c = ad[17:10];
    return c == 8'd1 ? 4'd3 :
           c == 8'd2 ? (ad[4:0] == 5'd0 ? 4'd1 : 4'd2) :
           c == 8'd3 ? 4'd9 :
           c == 8'd4 ? (ad[9:5] == 5'd0 ? 4'd5 : 4'd6) : 4'd0;
  endfunction
  always @(posedge clk) begin
    bus.atr_dt <= atr[bus.atr_ad];
    bus.chr_dt <= pat(bus.chr_ad);
  end
  function automatic logic [31:0] mk(input int code, input int y, input int x, input int sz,
                                     input int fx, input int fy, input int col);
    return {3'(col), 1'b1, 1'(fy), 1'(fx), 1'(sz), 9'(x), 8'(y), 8'(code)};
  endfunction
  task automatic clear_atr();
    for (int i = 0; i < 64; i++) atr[i] = '0;
  endtask
  task automatic start_line(input int v);
    bus.line_start = 1'b1;
    bus.line_v = 9'(v);
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", bus.busy, n);
    end
  endtask
  task automatic read_px(input int px, output logic [6:0] col, output logic opq);
    bus.pix_en = 1'b1;
    bus.pix_x = 9'(px);
    @(negedge clk);
    bus.pix_en = 1'b0;
    col = bus.pix_col;
    opq = bus.pix_opq;
  endtask
  task automatic test_reset();
    #1;
    n_tests++;
    if ({bus.busy, bus.ovf, bus.late, bus.pix_opq} !== 4'b0000 || bus.pix_col !== 7'h00 ||
        bus.atr_ad !== 6'd0 || bus.chr_ad !== 18'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b ovf=%b late=%b opq=%b col=%h atr_ad=%h chr_ad=%h, want all 0",
               bus.busy, bus.ovf, bus.late, bus.pix_opq, bus.pix_col, bus.atr_ad, bus.chr_ad);
    end
  endtask
  task automatic test_basic();
    logic [6:0] c;
    logic o;
    clear_atr();
    atr[0] = mk(1, 50, 100, 0, 0, 0, 5);
    atr[1] = mk(1, 50, 280, 0, 0, 0, 2);
    start_line(50);
    wait_idle();
    start_line(300);
    n_tests++;
    if (bus.ovf !== 1'b0 || bus.late !== 1'b0) begin
      n_fail++;
      $display("FAIL basic flags: ovf=%b late=%b, want 0 0", bus.ovf, bus.late);
    end
    wait_idle();
    for (int i = 99; i <= 116; i++) begin
      if (i != 110) begin
        read_px(i, c, o);
        n_tests++;
        if ((i == 99 || i == 116) ? (o !== 1'b0) : (o !== 1'b1 || c !== 7'h53)) begin
          n_fail++;
          $display("FAIL basic col %0d: got opq=%b col=%h, want opq=%0d col=53",
                   i, o, c, (i == 99 || i == 116) ? 0 : 1);
        end
      end
    end
    read_px(100, c, o);
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL reread col 100: got opq=%b, want 0", o); end
    read_px(287, c, o);
    n_tests++;
    if (o !== 1'b1 || c !== 7'h23) begin n_fail++; $display("FAIL edge col 287: got opq=%b col=%h, want 1 23", o, c); end
    read_px(288, c, o);
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL edge col 288: got opq=%b, want 0", o); end
    read_px(511, c, o);
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL edge col 511: got opq=%b, want 0", o); end
    bus.line_start = 1'b1;
    bus.line_v = 9'd300;
    bus.pix_en = 1'b1;
    bus.pix_x = 9'd110;
    @(negedge clk);
    bus.line_start = 1'b0;
    bus.pix_en = 1'b0;
    n_tests++;
    if (bus.pix_opq !== 1'b1 || bus.pix_col !== 7'h53) begin
      n_fail++;
      $display("FAIL read at swap col 110: got opq=%b col=%h, want 1 53", bus.pix_opq, bus.pix_col);
    end
    wait_idle();
  endtask
  task automatic test_priority();
    logic [6:0] c;
    logic o;
    int cols [7] = '{29, 30, 39, 40, 45, 55, 56};
    logic [7:0] want [7] = '{8'h00, 8'h69, 8'h69, 8'h23, 8'h23, 8'h23, 8'h00};
    clear_atr();
    atr[0] = mk(1, 10, 40, 0, 0, 0, 2);
    atr[1] = mk(3, 5, 30, 0, 0, 0, 6);
    start_line(10);
    wait_idle();
    start_line(300);
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      read_px(cols[i], c, o);
      n_tests++;
      if (o !== (want[i] != 8'h00) || (o && c !== want[i][6:0])) begin
        n_fail++;
        $display("FAIL priority col %0d: got opq=%b col=%h, want col=%h (00 = empty)", cols[i], o, c, want[i]);
      end
    end
  endtask
  task automatic test_overflow();
    logic [6:0] c;
    logic o;
    int cols [5] = '{0, 240, 255, 256, 287};
    logic [7:0] want [5] = '{8'h03, 8'h73, 8'h73, 8'h00, 8'h00};
    clear_atr();
    for (int i = 0; i < 16; i++) atr[i] = mk(1, 8, i * 16, 0, 0, 0, i % 8);
    start_line(8);
    wait_idle();
    start_line(300);
    n_tests++;
    if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf at 16 hits: got %b, want 0", bus.ovf); end
    wait_idle();
    for (int i = 16; i < 20; i++) atr[i] = mk(1, 8, i * 16, 0, 0, 0, i % 8);
    start_line(8);
    wait_idle();
    start_line(300);
    n_tests++;
    if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf at 20 hits: got %b, want 1", bus.ovf); end
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      read_px(cols[i], c, o);
      n_tests++;
      if (o !== (want[i] != 8'h00) || (o && c !== want[i][6:0])) begin
        n_fail++;
        $display("FAIL overflow col %0d: got opq=%b col=%h, want col=%h (00 = empty)", cols[i], o, c, want[i]);
      end
    end
    start_line(300);
    n_tests++;
    if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf after empty line: got %b, want 0", bus.ovf); end
    wait_idle();
  endtask
  task automatic test_flip();
    logic [6:0] c;
    logic o;
    int cols [8] = '{200, 231, 232, 0, 19, 20, 260, 276};
    logic [7:0] want [8] = '{8'h12, 8'h11, 8'h00, 8'h32, 8'h32, 8'h00, 8'h45, 8'h00};
    clear_atr();
    atr[0] = mk(2, 60, 200, 1, 1, 0, 1);
    atr[1] = mk(2, 60, 500, 1, 0, 0, 3);
    atr[2] = mk(4, 45, 260, 0, 0, 1, 4);
    start_line(60);
    wait_idle();
    start_line(300);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      read_px(cols[i], c, o);
      n_tests++;
      if (o !== (want[i] != 8'h00) || (o && c !== want[i][6:0])) begin
        n_fail++;
        $display("FAIL flip col %0d: got opq=%b col=%h, want col=%h (00 = empty)", cols[i], o, c, want[i]);
      end
    end
  endtask
  task automatic test_late();
    logic [6:0] c;
    logic o;
    clear_atr();
    atr[0] = mk(1, 70, 150, 1, 0, 0, 7);
    start_line(70);
    repeat (19) @(negedge clk);
    bus.line_start = 1'b1;
    bus.line_v = 9'd300;
    @(negedge clk);
    bus.line_start = 1'b0;
    n_tests++;
    if (bus.late !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL late pulse: late=%b busy=%b, want 1 1", bus.late, bus.busy);
    end
    @(negedge clk);
    n_tests++;
    if (bus.late !== 1'b0) begin n_fail++; $display("FAIL late width: late=%b, want 0", bus.late); end
    wait_idle();
    for (int i = 150; i <= 170; i += 10) begin
      read_px(i, c, o);
      n_tests++;
      if (o !== 1'b0) begin n_fail++; $display("FAIL abandoned col %0d: got opq=%b, want 0", i, o); end
    end
    start_line(70);
    wait_idle();
    start_line(300);
    wait_idle();
    read_px(151, c, o);
    n_tests++;
    if (o !== 1'b1 || c !== 7'h73) begin n_fail++; $display("FAIL render after abort col 151: got opq=%b col=%h, want 1 73", o, c); end
  endtask
  task automatic test_reset_mid_draw();
    logic [6:0] c;
    logic o;
    read_px(152, c, o);
    n_tests++;
    if (o !== 1'b1 || c !== 7'h73) begin n_fail++; $display("FAIL pre-reset col 152: got opq=%b col=%h, want 1 73", o, c); end
    clear_atr();
    atr[0] = mk(1, 90, 10, 1, 0, 0, 2);
    start_line(90);
    repeat (10) @(negedge clk);
    n_tests++;
    if (bus.chr_ad[17:10] !== 8'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid draw: chr_ad=%h busy=%b, want code 01 busy 1", bus.chr_ad, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.ovf, bus.late, bus.pix_opq} !== 4'b0000 || bus.pix_col !== 7'h00 ||
        bus.atr_ad !== 6'd0 || bus.chr_ad !== 18'd0) begin
      n_fail++;
      $display("FAIL async reset: busy=%b ovf=%b late=%b opq=%b col=%h atr_ad=%h chr_ad=%h, want all 0",
               bus.busy, bus.ovf, bus.late, bus.pix_opq, bus.pix_col, bus.atr_ad, bus.chr_ad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_px(153, c, o);
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL post-reset col 153: got opq=%b, want 0", o); end
    start_line(300);
    wait_idle();
    for (int i = 10; i <= 30; i += 10) begin
      read_px(i, c, o);
      n_tests++;
      if (o !== 1'b0) begin n_fail++; $display("FAIL post-reset col %0d: got opq=%b, want 0", i, o); end
    end
  endtask
  initial begin
    bus.line_start = 1'b0;
    bus.line_v = '0;
    bus.pix_en = 1'b0;
    bus.pix_x = '0;
    clear_atr();
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_priority();
    test_overflow();
    test_flip();
    test_late();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
